// File: rtl/psum_accumulator_if.sv
// Bundle-in / tile-out bus of the partial-sum accumulator.
// The master side is the producer/consumer around the accumulator, and the slave side is the accumulator.
interface psum_accumulator_if #(
    parameter int col_length = 5,
    parameter int wordlength = 16,
    parameter int acc_width  = 40
);
    logic                          in_valid;
    logic                          in_ready;
    logic [5:0]                    in_channel;
    logic [8*wordlength-1:0]       prod_in;
    logic [4*col_length-1:0]       prod_rows;
    logic [4*col_length-1:0]       prod_cols;
    logic                          drain;
    logic                          busy;
    logic                          err_channel;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [acc_width-1:0]   data_out;
    logic [col_length-1:0]         out_row;
    logic [col_length-1:0]         out_col;
    logic [5:0]                    out_channel;
    logic                          out_last;

    modport master (
        output in_valid, in_channel, prod_in, prod_rows, prod_cols, drain, out_ready,
        input  in_ready, busy, err_channel, out_valid, data_out, out_row, out_col,
               out_channel, out_last
    );

    modport slave (
        input  in_valid, in_channel, prod_in, prod_rows, prod_cols, drain, out_ready,
        output in_ready, busy, err_channel, out_valid, data_out, out_row, out_col,
               out_channel, out_last
    );
endinterface

// File: rtl/psum_accumulator.sv
// Serialises 4-lane PE product bundles into a read-modify-write partial-sum tile.
// On request, the tile is streamed out in raster order, and each entry is cleared as it is read.
module psum_accumulator #(
    parameter int col_length = 5,
    parameter int wordlength = 16,
    parameter int acc_width  = 40,
    parameter int out_rows   = 8,
    parameter int out_cols   = 8
) (
    input logic               clk,
    input logic               irst_n,
    psum_accumulator_if.slave bus
);
    localparam int N      = out_rows * out_cols;
    localparam int ADDR_W = $clog2(N);
    localparam int PW     = 2 * wordlength;
    localparam logic [col_length-1:0] ROW_LIM   = col_length'(out_rows);
    localparam logic [col_length-1:0] COL_LIM   = col_length'(out_cols);
    localparam logic [col_length-1:0] COL_LAST  = col_length'(out_cols - 1);
    localparam logic [ADDR_W-1:0]     ADDR_LAST = ADDR_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN} state_t;

    function automatic logic signed [acc_width-1:0] acc_add(
        input logic signed [acc_width-1:0] acc,
        input logic signed [PW-1:0]        prod
    );
        return acc + acc_width'(prod);
    endfunction

    state_t                       state_q, state_d;
    logic [1:0]                   lane_q, lane_d;
    logic                         drain_pend_q, drain_pend_d;
    logic                         tag_vld_q, tag_vld_d;
    logic [5:0]                   tag_q, tag_d;
    logic                         err_q, err_d;
    logic                         skip_q, skip_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [col_length-1:0]        drow_q, drow_d, dcol_q, dcol_d;
    logic signed [PW-1:0]         prod_q [4];
    logic signed [PW-1:0]         prod_d [4];
    logic [col_length-1:0]        row_q [4];
    logic [col_length-1:0]        row_d [4];
    logic [col_length-1:0]        col_q [4];
    logic [col_length-1:0]        col_d [4];
    logic signed [acc_width-1:0]  tile_q [N];

    logic                         in_ready, out_valid, busy;
    logic                         accept, beat, drain_done;
    logic signed [PW-1:0]         lane_prod;
    logic [col_length-1:0]        lane_row, lane_col;
    logic                         lane_in_range;
    logic [ADDR_W-1:0]            lane_addr;
    logic                         wr_en;
    logic [ADDR_W-1:0]            wr_addr;
    logic signed [acc_width-1:0]  wr_data;

    always_ff @(posedge clk) begin
        if (irst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept)            state_d = S_ACC;
                else if (drain_pend_q) state_d = S_DRAIN;
            end
            S_ACC: begin
                if (lane_q == 2'd3) begin
                    if (accept)            state_d = S_ACC;
                    else if (drain_pend_q) state_d = S_DRAIN;
                    else                   state_d = S_IDLE;
                end
            end
            S_DRAIN: if (drain_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = drain_pend_q || (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  in_ready  = !drain_pend_q;
            S_ACC:   in_ready  = (lane_q == 2'd3) && !drain_pend_q;
            S_DRAIN: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept     = bus.in_valid && in_ready;
    assign beat       = out_valid && bus.out_ready;
    assign drain_done = beat && (addr_q == ADDR_LAST);

    // Lane serialiser: one tile read-modify-write per cycle, with drain clears on the same port
    assign lane_prod     = prod_q[lane_q];
    assign lane_row      = row_q[lane_q];
    assign lane_col      = col_q[lane_q];
    assign lane_in_range = (lane_row < ROW_LIM) && (lane_col < COL_LIM);
    assign lane_addr     = ADDR_W'(lane_row) * ADDR_W'(out_cols) + ADDR_W'(lane_col);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr_q;
        wr_data = '0;
        if (state_q == S_ACC && lane_in_range && !skip_q) begin
            wr_en   = 1'b1;
            wr_addr = lane_addr;
            wr_data = acc_add(tile_q[lane_addr], lane_prod);
        end else if (beat) begin
            wr_en   = 1'b1;
            wr_addr = addr_q;
        end
    end

    always_comb begin
        lane_d       = lane_q;
        drain_pend_d = drain_pend_q;
        tag_vld_d    = tag_vld_q;
        tag_d        = tag_q;
        err_d        = err_q;
        skip_d       = skip_q;
        addr_d       = addr_q;
        drow_d       = drow_q;
        dcol_d       = dcol_q;
        prod_d       = prod_q;
        row_d        = row_q;
        col_d        = col_q;

        if (bus.drain) drain_pend_d = 1'b1;
        if (state_q == S_ACC) lane_d = lane_q + 2'd1;

        if (accept) begin
            lane_d = 2'd0;
            for (int k = 0; k < 4; k++) begin
                prod_d[k] = bus.prod_in[PW*k +: PW];
                row_d[k]  = bus.prod_rows[col_length*k +: col_length];
                col_d[k]  = bus.prod_cols[col_length*k +: col_length];
            end
            // A bundle for a foreign channel still occupies its four lane slots, but it writes nothing
            if (!tag_vld_q) begin
                tag_vld_d = 1'b1;
                tag_d     = bus.in_channel;
                skip_d    = 1'b0;
            end else if (bus.in_channel != tag_q) begin
                skip_d = 1'b1;
                err_d  = 1'b1;
            end else begin
                skip_d = 1'b0;
            end
        end

        if (beat) begin
            addr_d = addr_q + ADDR_W'(1);
            if (dcol_q == COL_LAST) begin
                dcol_d = '0;
                drow_d = drow_q + col_length'(1);
            end else begin
                dcol_d = dcol_q + col_length'(1);
            end
        end

        if (drain_done) begin
            addr_d       = '0;
            drow_d       = '0;
            dcol_d       = '0;
            drain_pend_d = 1'b0;
            tag_vld_d    = 1'b0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (irst_n) begin
            lane_q       <= '0;
            drain_pend_q <= 1'b0;
            tag_vld_q    <= 1'b0;
            tag_q        <= '0;
            err_q        <= 1'b0;
            skip_q       <= 1'b0;
            addr_q       <= '0;
            drow_q       <= '0;
            dcol_q       <= '0;
        end else begin
            lane_q       <= lane_d;
            drain_pend_q <= drain_pend_d;
            tag_vld_q    <= tag_vld_d;
            tag_q        <= tag_d;
            err_q        <= err_d;
            skip_q       <= skip_d;
            addr_q       <= addr_d;
            drow_q       <= drow_d;
            dcol_q       <= dcol_d;
        end
    end

    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        row_q  <= row_d;
        col_q  <= col_d;
    end

    always_ff @(posedge clk) begin
        if (irst_n) begin
            for (int i = 0; i < N; i++) tile_q[i] <= '0;
        end else if (wr_en) begin
            tile_q[wr_addr] <= wr_data;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.busy        = busy;
    assign bus.err_channel = err_q;
    assign bus.out_valid   = out_valid;
    assign bus.data_out    = out_valid ? tile_q[addr_q] : '0;
    assign bus.out_row     = out_valid ? drow_q : '0;
    assign bus.out_col     = out_valid ? dcol_q : '0;
    assign bus.out_channel = tag_q;
    assign bus.out_last    = out_valid && (addr_q == ADDR_LAST);
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator that checks each step against hand-computed values and a partial-sum model.
module tb_psum_accumulator;
  localparam int CL = 5;
  localparam int WL = 16;
  localparam int AW = 40;
  localparam int NR = 8;
  localparam int NC = 8;
  localparam int N  = NR * NC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psum_accumulator_if #(.col_length(CL), .wordlength(WL), .acc_width(AW)) bus ();

  psum_accumulator #(
    .col_length(CL), .wordlength(WL), .acc_width(AW), .out_rows(NR), .out_cols(NC)
  ) dut (
    .clk    (clk),
    .irst_n (rst),
    .bus    (bus)
  );

  int ncmp = 0;
  int nerr = 0;
  longint exp_t [N];
  longint got [N];
  logic signed [31:0] bp [4];
  logic [4:0] br [4];
  logic [4:0] bc [4];
  logic m_tag_vld = 1'b0;
  logic [5:0] m_tag = '0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint wrap40(input longint v);
    logic signed [39:0] t;
    t = v[39:0];
    return longint'(t);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) exp_t[i] = 0;
    m_tag_vld = 1'b0;
  endtask

  task automatic lane(input int k, input logic signed [31:0] p, input int r, input int c);
    bp[k] = p;
    br[k] = 5'(r);
    bc[k] = 5'(c);
  endtask

  task automatic apply(input logic [5:0] ch);
    bus.in_channel = ch;
    for (int k = 0; k < 4; k++) begin
      bus.prod_in[32*k +: 32]  = bp[k];
      bus.prod_rows[5*k +: 5]  = br[k];
      bus.prod_cols[5*k +: 5]  = bc[k];
    end
  endtask

  task automatic model_accept(input logic [5:0] ch);
    logic skip;
    int a;
    skip = 1'b0;
    if (!m_tag_vld) begin
      m_tag_vld = 1'b1;
      m_tag = ch;
    end else if (ch != m_tag) begin
      skip = 1'b1;
    end
    if (!skip)
      for (int k = 0; k < 4; k++)
        if (int'(br[k]) < NR && int'(bc[k]) < NC) begin
          a = int'(br[k]) * NC + int'(bc[k]);
          exp_t[a] = wrap40(exp_t[a] + longint'(bp[k]));
        end
  endtask

  task automatic send_bundle(input logic [5:0] ch);
    int w;
    apply(ch);
    bus.in_valid = 1'b1;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    model_accept(ch);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (bus.busy === 1'b1 && w < 40) begin
      step();
      w++;
    end
    check("idle_wait", bus.busy, 0);
  endtask

  task automatic drain_run(input string tag, input int stall_beat, input int abort_beat);
    int w;
    bus.out_ready = 1'b1;
    bus.drain = 1'b1;
    step();
    bus.drain = 1'b0;
    for (int b = 0; b < N; b++) begin
      w = 0;
      while (bus.out_valid !== 1'b1 && w < 10) begin
        step();
        w++;
      end
      check($sformatf("%s valid b%0d", tag, b), bus.out_valid, 1);
      if (bus.out_valid !== 1'b1) return;
      if (b == abort_beat) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check($sformatf("%s valid after reset", tag), bus.out_valid, 0);
        check($sformatf("%s busy after reset", tag), bus.busy, 0);
        return;
      end
      got[b] = bus.data_out;
      check($sformatf("%s data b%0d", tag, b), bus.data_out, exp_t[b]);
      check($sformatf("%s row b%0d", tag, b), bus.out_row, b / NC);
      check($sformatf("%s col b%0d", tag, b), bus.out_col, b % NC);
      check($sformatf("%s last b%0d", tag, b), bus.out_last, (b == N - 1) ? 1 : 0);
      if (b == stall_beat) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          check($sformatf("%s stall valid s%0d", tag, s), bus.out_valid, 1);
          check($sformatf("%s stall data s%0d", tag, s), bus.data_out, exp_t[b]);
          check($sformatf("%s stall row s%0d", tag, s), bus.out_row, b / NC);
          check($sformatf("%s stall col s%0d", tag, s), bus.out_col, b % NC);
        end
        bus.out_ready = 1'b1;
      end
      step();
    end
    for (int i = 0; i < N; i++) exp_t[i] = 0;
    m_tag_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_channel = '0;
    bus.prod_in = '0;
    bus.prod_rows = '0;
    bus.prod_cols = '0;
    bus.drain = 1'b0;
    bus.out_ready = 1'b0;
    clear_model();
    repeat (3) step();
    rst = 1'b0;

    // reset state
    check("rst busy", bus.busy, 0);
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst err", bus.err_channel, 0);
    check("rst data_out", bus.data_out, 0);
    check("rst out_channel", bus.out_channel, 0);
    check("rst out_last", bus.out_last, 0);

    // single bundle, two lanes colliding on (0,0)
    lane(0, 2, 0, 0); lane(1, -3, 0, 1); lane(2, 4, 7, 7); lane(3, 5, 0, 0);
    send_bundle(6'd5);
    check("t1 busy during acc", bus.busy, 1);
    wait_idle();
    check("t1 out_channel", bus.out_channel, 5);
    drain_run("t1", -1, -1);
    check("t1 beat0", got[0], 7);
    check("t1 beat1", got[1], -3);
    check("t1 beat63", got[63], 4);
    wait_idle();

    // three back-to-back bundles: accepts at t, t+4, t+8
    lane(0, 10, 1, 1); lane(1, 20, 1, 1); lane(2, 30, 2, 3); lane(3, 40, 4, 5);
    apply(6'd3);
    bus.in_valid = 1'b1;
    check("t2 ready t", bus.in_ready, 1);
    model_accept(6'd3);
    step();
    lane(0, -7, 1, 1); lane(1, 100, 3, 3); lane(2, 1, 2, 3); lane(3, -1, 7, 0);
    apply(6'd3);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("t2 ready t+%0d", i), bus.in_ready, 0);
      step();
    end
    check("t2 ready t+4", bus.in_ready, 1);
    model_accept(6'd3);
    step();
    lane(0, 1000, 0, 7); lane(1, -2000, 6, 6); lane(2, 5, 1, 1); lane(3, 6, 4, 5);
    apply(6'd3);
    for (int i = 5; i < 8; i++) begin
      check($sformatf("t2 ready t+%0d", i), bus.in_ready, 0);
      step();
    end
    check("t2 ready t+8", bus.in_ready, 1);
    model_accept(6'd3);
    step();
    bus.in_valid = 1'b0;
    wait_idle();
    drain_run("t2", -1, -1);
    check("t2 (1,1)", got[9], 28);
    check("t2 (2,3)", got[19], 31);
    check("t2 (4,5)", got[37], 46);
    check("t2 (6,6)", got[54], -2000);
    check("t2 (7,0)", got[56], -1);
    wait_idle();

    // out-of-range lanes are dropped
    lane(0, 9, 8, 3); lane(1, 11, 0, 2); lane(2, 12, 3, 8); lane(3, -4, 5, 5);
    send_bundle(6'd2);
    wait_idle();
    drain_run("t3", -1, -1);
    check("t3 alias (0,3)", got[3], 0);
    check("t3 (0,2)", got[2], 11);
    check("t3 (5,5)", got[45], -4);
    wait_idle();

    // channel mismatch
    lane(0, 1, 0, 0); lane(1, 2, 0, 1); lane(2, 3, 0, 2); lane(3, 4, 0, 3);
    send_bundle(6'd5);
    check("t4 err after first", bus.err_channel, 0);
    lane(0, 100, 0, 0); lane(1, 100, 0, 1); lane(2, 100, 0, 2); lane(3, 100, 0, 4);
    send_bundle(6'd6);
    check("t4 err after second", bus.err_channel, 1);
    wait_idle();
    check("t4 err sticky", bus.err_channel, 1);
    drain_run("t4", -1, -1);
    check("t4 (0,0)", got[0], 1);
    check("t4 (0,4)", got[4], 0);
    check("t4 err cleared", bus.err_channel, 0);
    wait_idle();

    // backpressure at beat 10
    lane(0, 77, 1, 2); lane(1, -5, 1, 3); lane(2, 3, 1, 2); lane(3, 0, 7, 7);
    send_bundle(6'd1);
    wait_idle();
    drain_run("t5", 10, -1);
    check("t5 beat10", got[10], 80);
    check("t5 beat11", got[11], -5);
    wait_idle();

    // reset mid-drain
    lane(0, 50, 3, 0); lane(1, 60, 2, 4); lane(2, 70, 7, 7); lane(3, 0, 0, 0);
    send_bundle(6'd4);
    wait_idle();
    drain_run("t6", -1, 20);
    clear_model();
    wait_idle();
    check("t6 out_channel reset", bus.out_channel, 0);
    drain_run("t6b", -1, -1);
    check("t6b (3,0)", got[24], 0);
    check("t6b (7,7)", got[63], 0);
    wait_idle();

    // accumulate 256 * (2^31-1) at (2,2): 2^39-256 is the largest such multiple that fits in the signed range
    lane(0, 32'sh7FFF_FFFF, 2, 2); lane(1, 32'sh7FFF_FFFF, 2, 2);
    lane(2, 32'sh7FFF_FFFF, 2, 2); lane(3, 32'sh7FFF_FFFF, 2, 2);
    for (int i = 0; i < 64; i++) send_bundle(6'd7);
    wait_idle();
    drain_run("t7a", -1, -1);
    check("t7a (2,2)", got[18], 64'sd549755813632);
    wait_idle();

    // 300 * (2^31-1) exceeds 2^39-1 and wraps negative
    for (int i = 0; i < 75; i++) send_bundle(6'd7);
    wait_idle();
    drain_run("t7b", -1, -1);
    check("t7b (2,2)", got[18], -64'sd455266533676);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
